// File: rtl/ts4231_pkg.sv
// ---------------------------------------------------------------------------
// ts4231_pkg
// Shared types and constants for the TS4231 configuration scheduler:
//   - sched_state_e : top-level scheduler states
//   - ser_phase_e   : bit-level serializer phases (one phase per half-bit slot)
//   - CFG_BITS, CFG_WORD_DEFAULT : configuration word width and typical value
// ---------------------------------------------------------------------------
package ts4231_pkg;

    localparam int CFG_BITS = 15;
    localparam logic [CFG_BITS-1:0] CFG_WORD_DEFAULT = 15'h392B;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LIGHT,
        WRITE,
        READ,
        GO_WATCH,
        NEXT,
        DONE
    } sched_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_E,
        S_PRE_D,
        S_BIT_LO,
        S_BIT_HI,
        S_POST_LO,
        S_POST_HI,
        S_ACK
    } ser_phase_e;

endpackage

// File: rtl/ts4231_cfg_shifter.sv
// ---------------------------------------------------------------------------
// ts4231_cfg_shifter
// Bit-level serializer for one TS4231 D/E pair. A go_i pulse starts a write
// (rw_i=0) or read (rw_i=1) frame of 34 half-bit slots; ack_o pulses one
// cycle after the frame, with rdata_o holding the captured word.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   go_i, rw_i, wdata_i  frame request, direction, word to write
//   ack_o, rdata_o       frame complete pulse, captured read word
//   d_o, d_oe_o          D drive value / enable
//   e_o, e_oe_o          E drive value / enable
//   d_i                  synchronized D pin value (read sampling)
// ---------------------------------------------------------------------------
module ts4231_cfg_shifter
    import ts4231_pkg::*;
#(
    parameter int HALF_BIT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                go_i,
    input  logic                rw_i,
    input  logic [CFG_BITS-1:0] wdata_i,
    output logic                ack_o,
    output logic [CFG_BITS-1:0] rdata_o,
    output logic                d_o,
    output logic                d_oe_o,
    output logic                e_o,
    output logic                e_oe_o,
    input  logic                d_i
);

    localparam int SW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;

    ser_phase_e          phase_q, phase_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [3:0]          bit_q, bit_d;
    logic                rw_q, rw_d;
    logic [CFG_BITS-1:0] sh_q, sh_d;
    logic                slot_last;

    assign slot_last = (slot_q == SW'(HALF_BIT - 1));
    assign rdata_o   = sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= S_IDLE;
            slot_q  <= '0;
            bit_q   <= '0;
            rw_q    <= 1'b0;
            sh_q    <= '0;
        end else begin
            phase_q <= phase_d;
            slot_q  <= slot_d;
            bit_q   <= bit_d;
            rw_q    <= rw_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        slot_d  = slot_last ? '0 : slot_q + SW'(1);
        bit_d   = bit_q;
        rw_d    = rw_q;
        sh_d    = sh_q;
        ack_o   = 1'b0;
        d_o     = 1'b1;
        d_oe_o  = 1'b0;
        e_o     = 1'b1;
        e_oe_o  = 1'b0;

        case (phase_q)
            S_IDLE: begin
                slot_d = '0;
                if (go_i) begin
                    phase_d = S_PRE_E;
                    rw_d    = rw_i;
                    // A read frame starts from a cleared capture register.
                    sh_d    = rw_i ? '0 : wdata_i;
                    bit_d   = 4'(CFG_BITS - 1);
                end
            end
            S_PRE_E: begin
                e_oe_o = 1'b1;
                e_o    = 1'b0;
                d_oe_o = 1'b1;
                d_o    = 1'b1;
                if (slot_last) phase_d = S_PRE_D;
            end
            S_PRE_D: begin
                // Read frames hand D to the sensor from this slot onward.
                e_oe_o = 1'b1;
                e_o    = 1'b0;
                d_oe_o = !rw_q;
                d_o    = 1'b0;
                if (slot_last) phase_d = S_BIT_LO;
            end
            S_BIT_LO: begin
                e_oe_o = 1'b1;
                e_o    = 1'b0;
                d_oe_o = !rw_q;
                d_o    = sh_q[bit_q];
                if (slot_last) phase_d = S_BIT_HI;
            end
            S_BIT_HI: begin
                e_oe_o = 1'b1;
                e_o    = 1'b1;
                d_oe_o = !rw_q;
                d_o    = sh_q[bit_q];
                if (slot_last) begin
                    // Sensor data is taken on the last cycle of the E-high slot.
                    if (rw_q) sh_d[bit_q] = d_i;
                    if (bit_q == 4'd0) begin
                        phase_d = S_POST_LO;
                    end else begin
                        bit_d   = bit_q - 4'd1;
                        phase_d = S_BIT_LO;
                    end
                end
            end
            S_POST_LO: begin
                e_oe_o = 1'b1;
                e_o    = 1'b0;
                d_oe_o = 1'b1;
                d_o    = 1'b1;
                if (slot_last) phase_d = S_POST_HI;
            end
            S_POST_HI: begin
                e_oe_o = 1'b1;
                e_o    = 1'b1;
                d_oe_o = 1'b1;
                d_o    = 1'b1;
                if (slot_last) phase_d = S_ACK;
            end
            S_ACK: begin
                ack_o   = 1'b1;
                slot_d  = '0;
                phase_d = S_IDLE;
            end
            default: phase_d = S_IDLE;
        endcase
    end

endmodule

// File: rtl/ts4231_cfg_sched.sv
// ---------------------------------------------------------------------------
// ts4231_cfg_sched
// Configures an array of TS4231 sensors one after another through a single
// shared serializer: wait for light, write config word, read back and verify
// (with retries), then command watch state. Pins are released when idle so
// the per-sensor decoders own them.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, cfg_word       begin pulse, config word sampled at start
//   d_in, e_in            raw (asynchronous) D/E pin values per sensor
//   d_out, d_oe           D drive value / enable per sensor
//   e_out, e_oe           E drive value / enable per sensor
//   busy, done            run in progress, one-cycle completion pulse
//   cfg_ok                per-sensor result, valid when busy=0
// ---------------------------------------------------------------------------
module ts4231_cfg_sched
    import ts4231_pkg::*;
#(
    parameter int N_SENSORS     = 4,
    parameter int HALF_BIT      = 16,
    parameter int LIGHT_TIMEOUT = 32000000,
    parameter int MAX_RETRY     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CFG_BITS-1:0]  cfg_word,
    input  logic [N_SENSORS-1:0] d_in,
    input  logic [N_SENSORS-1:0] e_in,
    output logic [N_SENSORS-1:0] d_out,
    output logic [N_SENSORS-1:0] d_oe,
    output logic [N_SENSORS-1:0] e_out,
    output logic [N_SENSORS-1:0] e_oe,
    output logic                 busy,
    output logic                 done,
    output logic [N_SENSORS-1:0] cfg_ok
);

    localparam int IW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    // Input synchronizers; idle lines are pulled high.
    logic [N_SENSORS-1:0] d_meta_q, d_sync_q;
    logic [N_SENSORS-1:0] e_meta_q, e_sync_q, e_prev_q;
    logic [N_SENSORS-1:0] e_fall;

    sched_state_e         state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic [CFG_BITS-1:0]  word_q, word_d;
    logic [N_SENSORS-1:0] cfg_ok_q, cfg_ok_d;
    logic [31:0]          tmo_q, tmo_d;
    logic                 go_q, go_d;
    logic                 rw_q, rw_d;

    logic                 sh_ack, sh_d_o, sh_d_oe, sh_e_o, sh_e_oe;
    logic [CFG_BITS-1:0]  sh_rdata;

    assign e_fall = e_prev_q & ~e_sync_q;
    assign cfg_ok = cfg_ok_q;
    assign busy   = (state_q != IDLE) && (state_q != DONE);
    assign done   = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_meta_q <= '1;
            d_sync_q <= '1;
            e_meta_q <= '1;
            e_sync_q <= '1;
            e_prev_q <= '1;
        end else begin
            d_meta_q <= d_in;
            d_sync_q <= d_meta_q;
            e_meta_q <= e_in;
            e_sync_q <= e_meta_q;
            e_prev_q <= e_sync_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            retry_q  <= '0;
            word_q   <= '0;
            cfg_ok_q <= '0;
            tmo_q    <= '0;
            go_q     <= 1'b0;
            rw_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            retry_q  <= retry_d;
            word_q   <= word_d;
            cfg_ok_q <= cfg_ok_d;
            tmo_q    <= tmo_d;
            go_q     <= go_d;
            rw_q     <= rw_d;
        end
    end

    // tmo_q doubles as the light timeout and the watch-command cycle counter.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        retry_d  = retry_q;
        word_d   = word_q;
        cfg_ok_d = cfg_ok_q;
        tmo_d    = tmo_q + 32'd1;
        go_d     = 1'b0;
        rw_d     = rw_q;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (start) begin
                    word_d   = cfg_word;
                    idx_d    = '0;
                    retry_d  = '0;
                    cfg_ok_d = '0;
                    state_d  = WAIT_LIGHT;
                end
            end
            WAIT_LIGHT: begin
                if (e_fall[idx_q]) begin
                    go_d    = 1'b1;
                    rw_d    = 1'b0;
                    state_d = WRITE;
                end else if (tmo_q == 32'(LIGHT_TIMEOUT - 1)) begin
                    cfg_ok_d[idx_q] = 1'b0;
                    state_d         = NEXT;
                end
            end
            WRITE: begin
                if (sh_ack) begin
                    go_d    = 1'b1;
                    rw_d    = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                if (sh_ack) begin
                    if (sh_rdata == word_q) begin
                        tmo_d   = '0;
                        state_d = GO_WATCH;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        go_d    = 1'b1;
                        rw_d    = 1'b0;
                        state_d = WRITE;
                    end else begin
                        cfg_ok_d[idx_q] = 1'b0;
                        state_d         = NEXT;
                    end
                end
            end
            GO_WATCH: begin
                if (tmo_q == 32'(2 * HALF_BIT - 1)) begin
                    cfg_ok_d[idx_q] = 1'b1;
                    state_d         = NEXT;
                end
            end
            NEXT: begin
                retry_d = '0;
                tmo_d   = '0;
                if (idx_q == IW'(N_SENSORS - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = WAIT_LIGHT;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Only the sensor under configuration ever sees an enabled driver.
    always_comb begin
        d_out = '1;
        d_oe  = '0;
        e_out = '1;
        e_oe  = '0;
        case (state_q)
            WRITE, READ: begin
                d_out[idx_q] = sh_d_o;
                d_oe[idx_q]  = sh_d_oe;
                e_out[idx_q] = sh_e_o;
                e_oe[idx_q]  = sh_e_oe;
            end
            GO_WATCH: begin
                d_out[idx_q] = 1'b1;
                d_oe[idx_q]  = 1'b1;
                e_out[idx_q] = (tmo_q >= 32'(HALF_BIT));
                e_oe[idx_q]  = 1'b1;
            end
            default: ;
        endcase
    end

    ts4231_cfg_shifter #(
        .HALF_BIT (HALF_BIT)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .go_i    (go_q),
        .rw_i    (rw_q),
        .wdata_i (word_q),
        .ack_o   (sh_ack),
        .rdata_o (sh_rdata),
        .d_o     (sh_d_o),
        .d_oe_o  (sh_d_oe),
        .e_o     (sh_e_o),
        .e_oe_o  (sh_e_oe),
        .d_i     (d_sync_q[idx_q])
    );

endmodule

// File: tb/tb_ts4231_cfg_sched.sv
module tb_ts4231_cfg_sched;
    import ts4231_pkg::*;

    localparam int N     = 4;
    localparam int HB    = 16;
    localparam int TMO   = 1000;
    localparam int MR    = 3;
    localparam int FRAME = 34 * HB;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [14:0]    cfg_word;
    logic [N-1:0]   d_in, e_in, d_out, d_oe, e_out, e_oe, cfg_ok;
    logic           busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ts4231_cfg_sched #(
        .N_SENSORS     (N),
        .HALF_BIT      (HB),
        .LIGHT_TIMEOUT (TMO),
        .MAX_RETRY     (MR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cfg_word (cfg_word),
        .d_in     (d_in),
        .e_in     (e_in),
        .d_out    (d_out),
        .d_oe     (d_oe),
        .e_out    (e_out),
        .e_oe     (e_oe),
        .busy     (busy),
        .done     (done),
        .cfg_ok   (cfg_ok)
    );

    // ---------------- sensor model ----------------
    logic         model_clr;
    logic [N-1:0] dark;
    int           flips [N];

    int           runcnt;
    int           bad_len, own_bad;
    logic [N-1:0] in_frame, wr, eo_prev;
    int           rises [N];
    int           flen [N];
    logic [14:0]  shreg [N];
    logic [14:0]  mem [N];
    int           n_wr [N];
    int           n_rd [N];
    int           n_watch [N];
    logic         light_low;

    assign light_low = (runcnt >= 100) && (((runcnt - 100) % 200) < 4);

    always @(posedge clk) begin
        if (model_clr) begin
            runcnt  <= 0;
            bad_len <= 0;
            own_bad <= 0;
            for (int s = 0; s < N; s++) begin
                in_frame[s] <= 1'b0;
                wr[s]       <= 1'b0;
                eo_prev[s]  <= 1'b1;
                rises[s]    <= 0;
                flen[s]     <= 0;
                shreg[s]    <= '0;
                mem[s]      <= '0;
                n_wr[s]     <= 0;
                n_rd[s]     <= 0;
                n_watch[s]  <= 0;
            end
        end else begin
            runcnt <= runcnt + 1;
            if ($countones(d_oe | e_oe) > 1) own_bad <= own_bad + 1;
            for (int s = 0; s < N; s++) begin
                eo_prev[s] <= e_oe[s] ? e_out[s] : 1'b1;
                if (e_oe[s]) begin
                    if (!in_frame[s]) begin
                        in_frame[s] <= 1'b1;
                        rises[s]    <= 0;
                        flen[s]     <= 1;
                    end else begin
                        flen[s] <= flen[s] + 1;
                        if (e_out[s] && !eo_prev[s]) begin
                            rises[s] <= rises[s] + 1;
                            if (rises[s] == 0) wr[s] <= d_oe[s];
                            if (d_oe[s] && rises[s] < 15) shreg[s] <= {shreg[s][13:0], d_out[s]};
                        end
                    end
                end else if (in_frame[s]) begin
                    in_frame[s] <= 1'b0;
                    if (rises[s] == 16 && flen[s] == FRAME) begin
                        if (wr[s]) begin
                            n_wr[s] <= n_wr[s] + 1;
                            mem[s]  <= shreg[s];
                        end else begin
                            n_rd[s] <= n_rd[s] + 1;
                        end
                    end else if (rises[s] == 1 && flen[s] == 2 * HB) begin
                        n_watch[s] <= n_watch[s] + 1;
                    end else begin
                        bad_len <= bad_len + 1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pin
        logic [14:0] rdw;
        logic        rd_phase;
        int          bi;
        assign rdw      = mem[g] ^ ((n_rd[g] < flips[g]) ? 15'd1 : 15'd0);
        assign bi       = 15 - rises[g];
        assign rd_phase = in_frame[g] && e_oe[g] && !d_oe[g] && (rises[g] >= 1) && (rises[g] <= 15);
        assign d_in[g]  = d_oe[g] ? d_out[g] : (rd_phase ? rdw[bi[3:0]] : 1'b1);
        assign e_in[g]  = e_oe[g] ? e_out[g] : (dark[g] ? 1'b1 : !light_low);
    end

    // ---------------- reference rules ----------------
    function automatic int ref_attempts(input logic dk, input logic [3:0] f);
        int a;
        if (dk) return 0;
        a = int'(f) + 1;
        return (a < MR + 1) ? a : MR + 1;
    endfunction

    function automatic logic [N-1:0] ref_ok(input logic [N-1:0] dk, input logic [N-1:0][3:0] fl);
        logic [N-1:0] r;
        for (int s = 0; s < N; s++) r[s] = !dk[s] && (int'(fl[s]) <= MR);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_case(input string nm, input logic [14:0] w, input logic [N-1:0] dk,
                            input logic [N-1:0][3:0] fl, input int restart_at,
                            input logic [N-1:0] exp_ok);
        int cyc;
        int ndone;
        logic [N-1:0] mok;
        mok = ref_ok(dk, fl);
        @(negedge clk);
        dark = dk;
        for (int s = 0; s < N; s++) flips[s] = int'(fl[s]);
        model_clr = 1'b1;
        @(negedge clk);
        model_clr = 1'b0;
        cfg_word  = w;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, " busy_after_start"}, 32'(busy), 32'd1);
        cyc   = 0;
        ndone = 0;
        while (ndone == 0 && cyc < 40000) begin
            if (restart_at != 0 && cyc == restart_at) begin
                cfg_word = ~w;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (done) ndone++;
        end
        start    = 1'b0;
        cfg_word = w;
        chk({nm, " done_seen"}, 32'(ndone), 32'd1);
        chk({nm, " busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({nm, " done_one_cycle"}, 32'(done), 32'd0);
        chk({nm, " busy_after"}, 32'(busy), 32'd0);
        chk({nm, " cfg_ok"}, 32'(cfg_ok), 32'(exp_ok));
        for (int s = 0; s < N; s++) begin
            chk($sformatf("%s writes[%0d]", nm, s), 32'(n_wr[s]), 32'(ref_attempts(dk[s], fl[s])));
            chk($sformatf("%s reads[%0d]", nm, s), 32'(n_rd[s]), 32'(ref_attempts(dk[s], fl[s])));
            chk($sformatf("%s watch[%0d]", nm, s), 32'(n_watch[s]), 32'(mok[s]));
            if (!dk[s]) chk($sformatf("%s word[%0d]", nm, s), 32'(mem[s]), 32'(w));
        end
        chk({nm, " frame_shape"}, 32'(bad_len), 32'd0);
        chk({nm, " pin_owner"}, 32'(own_bad), 32'd0);
    endtask

    typedef struct {
        string            nm;
        logic [14:0]      word;
        logic [N-1:0]     dark;
        logic [N-1:0][3:0] flips;
        int               restart_at;
        logic [N-1:0]     exp_ok;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int cyc;
        logic [14:0]       rw;
        logic [N-1:0]      rdk;
        logic [N-1:0][3:0] rfl;

        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_word  = CFG_WORD_DEFAULT;
        dark      = '0;
        model_clr = 1'b1;
        for (int s = 0; s < N; s++) flips[s] = 0;
        repeat (3) @(negedge clk);
        chk("rst d_oe", 32'(d_oe), 32'd0);
        chk("rst e_oe", 32'(e_oe), 32'd0);
        chk("rst d_out", 32'(d_out), 32'hF);
        chk("rst e_out", 32'(e_out), 32'hF);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst cfg_ok", 32'(cfg_ok), 32'd0);
        rst_n = 1'b1;

        tbl[0] = '{"all_ok",   CFG_WORD_DEFAULT, 4'b0000, {4'd0, 4'd0, 4'd0,  4'd0}, 0,   4'b1111};
        tbl[1] = '{"dark2",    CFG_WORD_DEFAULT, 4'b0100, {4'd0, 4'd0, 4'd0,  4'd0}, 0,   4'b1011};
        tbl[2] = '{"retry2",   15'h2D69,         4'b0000, {4'd0, 4'd0, 4'd2,  4'd0}, 0,   4'b1111};
        tbl[3] = '{"nomatch1", CFG_WORD_DEFAULT, 4'b0000, {4'd0, 4'd0, 4'd15, 4'd0}, 0,   4'b1101};
        tbl[4] = '{"restart",  CFG_WORD_DEFAULT, 4'b0000, {4'd0, 4'd0, 4'd0,  4'd0}, 700, 4'b1111};

        for (int i = 0; i < 5; i++)
            run_case(tbl[i].nm, tbl[i].word, tbl[i].dark, tbl[i].flips, tbl[i].restart_at, tbl[i].exp_ok);

        // Reset in the middle of a write bit.
        @(negedge clk);
        dark = '0;
        for (int s = 0; s < N; s++) flips[s] = 0;
        model_clr = 1'b1;
        @(negedge clk);
        model_clr = 1'b0;
        cfg_word  = 15'h1234;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!(d_oe[0] && e_oe[0] && rises[0] == 5) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk("midbit_reached", 32'(cyc < 5000), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst d_oe", 32'(d_oe), 32'd0);
        chk("async_rst e_oe", 32'(e_oe), 32'd0);
        chk("async_rst busy", 32'(busy), 32'd0);
        chk("async_rst cfg_ok", 32'(cfg_ok), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_case("post_reset", 15'h1234, 4'b0000, {4'd0, 4'd0, 4'd0, 4'd0}, 0, 4'b1111);

        // Randomized runs checked against the reference rules.
        for (int r = 0; r < 2; r++) begin
            rw  = 15'($urandom);
            rdk = ($urandom_range(0, 1) == 1) ? N'(1 << $urandom_range(0, N - 1)) : '0;
            for (int s = 0; s < N; s++) rfl[s] = 4'($urandom_range(0, 1));
            run_case($sformatf("rand%0d", r), rw, rdk, rfl, 0, ref_ok(rdk, rfl));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
